// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Holds the architectural register indices, the default data width
// and the address-width helper used to size address ports.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_RA   = 31;

  // Number of address bits needed to index n registers (at least 1).
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A long-latency issue claims a register (sb_set); any committed write
// to that register releases it. A claim in the same cycle as a release
// keeps the bit set because the new producer now owns the register.
// Bit 0 is never set since register 0 is hardwired to zero.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LINK_REG = REG_RA
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sb_set,
  input  logic [addr_width(NUM_REGS)-1:0]   sb_addr,
  input  logic                              wr_en,
  input  logic [addr_width(NUM_REGS)-1:0]   wr_addr,
  input  logic                              link_en,
  output logic [NUM_REGS-1:0]               busy_vec
);

  localparam int AW = addr_width(NUM_REGS);
  localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Release on committed writes first, then apply the claim so set wins.
  always_comb begin
    busy_next = busy;
    if (wr_en)   busy_next[wr_addr]  = 1'b0;
    if (link_en) busy_next[LINK_IDX] = 1'b0;
    if (sb_set)  busy_next[sb_addr]  = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy bits register; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign busy_vec = busy;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port general-purpose register file with pending-write scoreboard.
// NUM_RD combinational read ports, one writeback port, one JAL link port
// (link wins over a writeback to the same register), and v0/a0/ra taps
// taken straight from the array.
// Optional build macro REGFILE_BYPASS_EN: read ports forward the data
// being committed this cycle and mask the busy flag of a register whose
// pending write is landing now. Without it, reads see only the array.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = REG_RA,
  parameter int V0_REG   = REG_V0,
  parameter int A0_REG   = REG_A0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_RD*addr_width(NUM_REGS)-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]                 rd_data,
  output logic [NUM_RD-1:0]                        rd_busy,
  input  logic                                     wr_en,
  input  logic [addr_width(NUM_REGS)-1:0]          wr_addr,
  input  logic [DATA_W-1:0]                        wr_data,
  input  logic                                     link_en,
  input  logic [DATA_W-1:0]                        link_data,
  input  logic                                     sb_set,
  input  logic [addr_width(NUM_REGS)-1:0]          sb_addr,
  output logic [NUM_REGS-1:0]                      busy_vec,
  output logic [DATA_W-1:0]                        v0,
  output logic [DATA_W-1:0]                        a0,
  output logic [DATA_W-1:0]                        ra
);

  localparam int AW = addr_width(NUM_REGS);
  localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
  localparam logic [AW-1:0] V0_IDX   = AW'(V0_REG);
  localparam logic [AW-1:0] A0_IDX   = AW'(A0_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_commit;

  // A writeback commits unless it targets r0 or collides with the link write.
  assign wr_commit = wr_en && (wr_addr != '0) && !(link_en && (wr_addr == LINK_IDX));

  // Register array; register 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_commit) regs[wr_addr]  <= wr_data;
      if (link_en)   regs[LINK_IDX] <= link_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LINK_REG (LINK_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .link_en  (link_en),
    .busy_vec (busy_vec)
  );

  assign v0 = regs[V0_IDX];
  assign a0 = regs[A0_IDX];
  assign ra = regs[LINK_IDX];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[p*AW +: AW];

    // Per-port read mux: array contents, optional same-cycle forwarding.
    always_comb begin
      data = regs[addr];
      busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
      if (link_en && (addr == LINK_IDX)) begin
        data = link_data;
        busy = 1'b0;
      end else if (wr_en && (addr == wr_addr) && (addr != '0)) begin
        data = wr_data;
        busy = 1'b0;
      end
`endif
      if (!rst_n || (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data;
    assign rd_busy[p]                  = busy;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised general-purpose register file, the successor to the single-ported MIPS register file.
- Provides NUM_RD combinational read ports, one ALU/load write port and one dedicated JAL link write port, and the v0/a0/ra taps used by syscall and JR logic.
- Adds a pending-write scoreboard so the decode stage can stall on registers owned by multi-cycle producers.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, >= 8)
- NUM_RD, 2, number of read ports (1..4)
- LINK_REG, 31, index written by the link port (ra)
- V0_REG, 2, index tapped on v0 output
- A0_REG, 4, index tapped on a0 output

Ports (AW = clog2(NUM_REGS)):
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- rd_addr  in  NUM_RD*AW  read addresses; port p occupies bits [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data; port p occupies bits [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port p's register has a pending write
- wr_en  in  1  writeback write strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  DATA_W  writeback data
- link_en  in  1  JAL link write strobe
- link_data  in  DATA_W  return address written to LINK_REG
- sb_set  in  1  mark sb_addr busy (long-latency op issued)
- sb_addr  in  AW  register being claimed
- busy_vec  out  NUM_REGS  full scoreboard state
- v0  out  DATA_W  contents of V0_REG
- a0  out  DATA_W  contents of A0_REG
- ra  out  DATA_W  contents of LINK_REG

Behaviour:
- Reset (rst_n low, any time, including mid-write):
  - all registers and busy bits clear to 0 immediately;
  - v0/a0/ra/rd_data read 0 and busy_vec/rd_busy read 0 while reset is held.
- Register 0 is hardwired to 0: writes to it are discarded, it can never be marked busy, and reads of it always return 0 with rd_busy=0.
- Writes commit at the rising edge of clk. wr_en and link_en are independent; both may commit in the same cycle.
- Write conflict: wr_en with wr_addr==LINK_REG and link_en in the same cycle -> link_data wins and wr_data is dropped.
- Reads are combinational from the array, with zero latency for stored values.
- v0/a0/ra come straight from the array (no bypass) and change the cycle after a write.
- Scoreboard bit k updates at the rising edge:
  - sets when sb_set & sb_addr==k & k!=0;
  - clears when a committed write (wr_en or link_en) targets k;
  - simultaneous set and clear of k -> set wins (new producer owns it).
- rd_busy[p] = busy[rd_addr[p]], subject to the bypass masking below.
- No internal backpressure: the block never refuses a write or a set.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd_data[p] returns the write data being committed this cycle when the address matches, with link taking priority over wr;
  - rd_busy[p] is masked to 0 when that same-cycle write resolves the pending register.
- Undefined:
  - rd_data returns only committed array contents; new data is visible the cycle after the write;
  - rd_busy is not masked.
- Reads of register 0 return 0 in both builds.

Decomposition:
- Shared package regfile_pkg:
  - register index constants REG_ZERO=0, REG_V0=2, REG_A0=4, REG_RA=31;
  - address-width helper function;
  - DATA_W default constant.
- One sub-module, regfile_scoreboard: owns the busy bits, the set/clear priority and busy_vec.
- The read/bypass muxing stays in the top level, generated per port.

Test Plan:
- rst_n low mid-run after writing 0xDEADBEEF to r5 -> r5, busy_vec and ra read 0 asynchronously without a clock edge.
- wr_en r0=0x1234, then read r0 on both ports -> 0; sb_set r0 -> busy_vec[0] stays 0.
- Same cycle: wr_en r31=0xAAAA0000 and link_en link_data=0x00400020 -> next cycle ra=0x00400020. With bypass, a same-cycle read of r31 returns 0x00400020.
- Write r8=0x55 with rd_addr port0=8 in the same cycle -> bypass build reads 0x55 that cycle; non-bypass build reads the old value, then 0x55 next cycle.
- sb_set r9, then 3 idle cycles -> rd_busy=1 on a port reading r9. wr_en r9=0x77 -> bypass build shows rd_busy=0 that cycle; busy_vec[9]=0 next cycle.
- Same cycle: sb_set r10 and wr_en r10=0x1 -> r10=0x1 and busy_vec[10]=1 next cycle.
